vga_scan_ctrl: RTL and testbench



---
 rtl/vga_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
//
// Raster scan controller for the VGA output path. Free-running horizontal and
// vertical counters form the pixel address handed to the GPU. The colour it
// returns, the sync pulses and the status strobes all pass through one output
// register stage, so every pin output lines up with the same count.
//
// Ports
//   sysclk        in   pixel clock, rising edge
//   reset         in   synchronous, active-high
//   display_data  in   [2:0] {R,G,B} from the GPU for the current display_addr
//   display_addr  out  [21:0] {h_cnt, v_cnt}, taken directly from the counters
//   vga_rgb       out  [2:0] registered colour, forced to 0 outside the visible area
//   hsync         out  registered horizontal sync, active level HSYNC_POL
//   vsync         out  registered vertical sync, active level VSYNC_POL
//   video_on      out  registered, high while vga_rgb carries a visible pixel
//   frame_start   out  registered one-cycle pulse, aligned with pixel (0,0) on vga_rgb
//   vblank        out  registered, high for lines v >= V_VISIBLE
//
// The H and V totals must each be no greater than 2048, because both
// counters are 11 bits wide.

module vga_scan_ctrl #(
    parameter int   H_VISIBLE = 800,
    parameter int   H_FRONT   = 56,
    parameter int   H_SYNC    = 120,
    parameter int   H_BACK    = 64,
    parameter int   V_VISIBLE = 600,
    parameter int   V_FRONT   = 37,
    parameter int   V_SYNC    = 6,
    parameter int   V_BACK    = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [2:0]  display_data,
    output logic [21:0] display_addr,
    output logic [2:0]  vga_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start,
    output logic        vblank
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;

    logic [2:0]  rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_on_q, video_on_d;
    logic        frame_start_q, frame_start_d;
    logic        vblank_q, vblank_d;

    // Decode of the current count, before the output register.
    logic vis;
    logic hs;
    logic vs;
    logic fs;
    logic vb;

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        // The vertical counter steps only on the horizontal wrap. At the last
        // count of the frame, both counters return to 0 in the same cycle.
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 11'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 11'd0;
            end else begin
                v_cnt_d = v_cnt_q + 11'd1;
            end
        end
    end

    always_comb begin
        vis = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs  = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q <= H_SYNC_END);
        vs  = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q <= V_SYNC_END);
        fs  = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
        vb  = (v_cnt_q >= V_VIS);
    end

    always_comb begin
        // Blanking is applied here, so whatever the GPU returns outside the
        // visible area never reaches the pins.
        rgb_d         = vis ? display_data : 3'b000;
        hsync_d       = hs ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = vs ? VSYNC_POL : ~VSYNC_POL;
        video_on_d    = vis;
        frame_start_d = fs;
        vblank_d      = vb;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            h_cnt_q       <= 11'd0;
            v_cnt_q       <= 11'd0;
            rgb_q         <= 3'b000;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
        end
    end

    assign display_addr = {h_cnt_q, v_cnt_q};
    assign vga_rgb      = rgb_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_on     = video_on_q;
    assign frame_start  = frame_start_q;
    assign vblank       = vblank_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Testbench for vga_scan_ctrl. The DUT uses a reduced raster (60 x 40 counts)
// so that whole frames fit in a short run. The GPU is a combinational model
// that returns h_cnt[2:0], or a constant 7 when gpu_force is set.

module tb_vga_scan_ctrl;

    localparam int HV = 40;
    localparam int HF = 5;
    localparam int HS = 8;
    localparam int HB = 7;
    localparam int VV = 30;
    localparam int VF = 3;
    localparam int VS = 2;
    localparam int VB = 5;
    localparam int HT = HV + HF + HS + HB;   // 60
    localparam int VT = VV + VF + VS + VB;   // 40
    localparam int FRAME = HT * VT;          // 2400

    logic        sysclk = 1'b0;
    logic        reset;
    logic [2:0]  display_data;
    logic [21:0] display_addr;
    logic [2:0]  vga_rgb;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        frame_start;
    logic        vblank;

    logic        gpu_force;

    int n_cmp = 0;
    int n_err = 0;

    vga_scan_ctrl #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
    ) u_dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .display_data (display_data),
        .display_addr (display_addr),
        .vga_rgb      (vga_rgb),
        .hsync        (hsync),
        .vsync        (vsync),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .vblank       (vblank)
    );

    always #5 sysclk = ~sysclk;

    // GPU model: display_addr[13:11] holds h_cnt[2:0].
    assign display_data = gpu_force ? 3'd7 : display_addr[13:11];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic [29:0] obs_vec();
        return {display_addr, vga_rgb, hsync, vsync, video_on, frame_start, vblank};
    endfunction

    // Sample p shows position p on the pins, while the counters, and so
    // display_addr, have already moved on to position p+1.
    function automatic logic [29:0] exp_vec(input int p, input bit frc);
        int h, v, n;
        logic vis, hs_e, vs_e;
        logic [2:0] rgb;
        h    = p % HT;
        v    = p / HT;
        n    = (p + 1) % FRAME;
        vis  = (h < HV) && (v < VV);
        hs_e = (h >= HV + HF) && (h < HV + HF + HS);
        vs_e = (v >= VV + VF) && (v < VV + VF + VS);
        rgb  = vis ? (frc ? 3'd7 : 3'(h % 8)) : 3'd0;
        return {11'(n % HT), 11'(n / HT), rgb, hs_e, vs_e, vis, (p == 0), (v >= VV)};
    endfunction

    initial begin
        int nfs, fs_first, fs_second;
        int hs_cnt0, hs_rise, von_cnt0, vs_cnt, vs_rise, vb_cnt, vb_prev_lines;
        int k;
        logic hs_prev, vs_prev;
        logic [21:0] target;

        reset     = 1'b1;
        gpu_force = 1'b1;

        // Reset held with non-zero GPU data: everything sits at its reset value.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_hold", 32'(obs_vec()), 32'd0);
        end

        reset     = 1'b0;
        gpu_force = 1'b0;

        nfs = 0; fs_first = -1; fs_second = -1;
        hs_cnt0 = 0; hs_rise = -1; von_cnt0 = 0;
        vs_cnt = 0; vs_rise = -1; vb_cnt = 0; vb_prev_lines = 0;
        hs_prev = 1'b0; vs_prev = 1'b0;

        // Two frames: the first with the h_cnt GPU model, the second with the GPU forced to 7.
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            chk("scan", 32'(obs_vec()), 32'(exp_vec(c % FRAME, c >= FRAME)));

            if (frame_start) begin
                nfs++;
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
            if (c < HT) begin
                if (hsync) hs_cnt0++;
                if (video_on) von_cnt0++;
                if (hsync && !hs_prev && hs_rise < 0) hs_rise = c;
            end
            if (c < FRAME) begin
                if (vsync) vs_cnt++;
                if (vsync && !vs_prev && vs_rise < 0) vs_rise = c;
                if (vblank) vb_cnt++;
            end
            hs_prev = hsync;
            vs_prev = vsync;

            if (c == 0) chk("first_fs", 32'(frame_start), 32'd1);
            if (c == 0) chk("first_addr", 32'(display_addr), 32'({11'd1, 11'd0}));
            if (c == FRAME - 2) chk("wrap_pre", 32'(display_addr), 32'({11'(HT - 1), 11'(VT - 1)}));
            if (c == FRAME - 1) chk("wrap_addr", 32'(display_addr), 32'd0);
            if (c == FRAME) chk("wrap_fs", 32'(frame_start), 32'd1);
            if (c == FRAME - 1) gpu_force = 1'b1;
        end

        chk("hsync_rise", 32'(hs_rise), 32'(HV + HF));
        chk("hsync_width", 32'(hs_cnt0), 32'(HS));
        chk("video_on_width", 32'(von_cnt0), 32'(HV));
        chk("vsync_rise", 32'(vs_rise), 32'((VV + VF) * HT));
        chk("vsync_width", 32'(vs_cnt), 32'(VS * HT));
        chk("vblank_width", 32'(vb_cnt), 32'((VT - VV) * HT));
        chk("fs_count", 32'(nfs), 32'd2);
        chk("fs_period", 32'(fs_second - fs_first), 32'(FRAME));

        // Reset mid-frame with both syncs active.
        gpu_force = 1'b0;
        target = {11'(HV + HF + 2), 11'(VV + VF + 1)};
        k = 0;
        while (display_addr != target && k < FRAME) begin
            tick();
            k++;
        end
        chk("mid_reach", 32'(k < FRAME), 32'd1);
        chk("mid_syncs_on", 32'({hsync, vsync}), 32'd3);
        reset = 1'b1;
        tick();
        chk("mid_syncs_off", 32'({hsync, vsync}), 32'd0);
        chk("mid_addr", 32'(display_addr), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_fs", 32'(frame_start), 32'd1);
        chk("mid_addr_run", 32'(display_addr), 32'({11'd1, 11'd0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
